board_controller: RTL
=====================

Name: board_controller

Overview:
- Downstream consumer of the per-player input stage's 3-bit {left,right,put} command vectors (local player and opponent link).
- Arbitrates by turn, moves a column cursor, and drops a piece into the lowest empty row of the selected column using a row-scan FSM.
- Exports board state, turn, drop events and column-full errors to the display and win-check stages.

Parameters:
- ROWS, 6, board rows; row 0 = bottom.
- COLS, 7, board columns; col 0 = leftmost.
- CW, 3, cursor/column index width; must satisfy 2**CW >= COLS.
- RW, 3, row index width; must satisfy 2**RW >= ROWS.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- lrp_self  in  3  local commands; bit2 left, bit1 right, bit0 put; one-cycle active-high pulses
- lrp_opponent  in  3  opponent commands, same encoding
- player_id  in  1  which player this board belongs to; player 0 moves first
- cursor_col  out  CW  current cursor column
- cell_valid  out  ROWS*COLS  occupancy; index = row*COLS+col
- cell_owner  out  ROWS*COLS  owner per cell; 0/1; meaningful only where valid
- turn  out  1  player whose move is pending
- busy  out  1  high in SEARCH/WRITE
- drop_done  out  1  one-cycle pulse on piece write
- drop_row  out  RW  row of last write; held until next write
- col_full_err  out  1  one-cycle pulse on put into full column
- board_full  out  1  high once ROWS*COLS pieces are placed

Behaviour:
- Reset values: cursor_col = COLS/2 (3); cell_valid = 0; cell_owner = 0; turn = 0; busy = 0; drop_done = 0; drop_row = 0; col_full_err = 0; board_full = 0; move counter = 0; FSM = IDLE.
- Source select: active = (turn == player_id) ? lrp_self : lrp_opponent. The inactive vector is ignored completely.
- IDLE, command decode on the active vector:
  - put=1 -> SEARCH with row=0; cursor frozen. Put has priority over left/right in the same cycle.
  - left=1 and right=1 (no put) -> no action.
  - left alone -> cursor decrements; saturates at 0.
  - right alone -> cursor increments; saturates at COLS-1.
- SEARCH, one row per cycle:
  - cell[row][cursor] empty -> WRITE.
  - occupied and row < ROWS-1 -> row+1.
  - occupied and row == ROWS-1 -> col_full_err pulse, return to IDLE; turn unchanged.
- WRITE, single cycle:
  - set cell_valid and cell_owner = turn at [row][cursor]; drop_row = row; drop_done pulse.
  - toggle turn; increment move counter; return to IDLE.
- Latency: put sampled at edge t; piece written at edge t+2+r for landing row r; drop_done is visible the cycle after that edge.
- All commands, including the inactive source's, are discarded while busy; no queuing.
- board_full: asserts when the move counter reaches ROWS*COLS. While board_full, put is ignored; left/right still move the cursor.
- rst mid-SEARCH/WRITE: abort, no partial write; all state returns to reset values.

Optional Feature:
- CURSOR_WRAP_EN defined: left at 0 -> COLS-1; right at COLS-1 -> 0.
- Undefined: saturating behaviour as above.

Decomposition:
- Package connect4_pkg:
  - ROWS/COLS defaults.
  - LRP bit indices LRP_LEFT=2, LRP_RIGHT=1, LRP_PUT=0.
  - FSM enum {IDLE, SEARCH, WRITE}.
  - cell index function row*COLS+col.
- Sub-module cursor_ctrl: owns cursor register, left/right decode, saturate/wrap logic and the freeze input. Top holds the board arrays and the FSM.

Test Plan:
- Reset, player_id=0, lrp_self=3'b001 for 1 cycle -> busy=1 for 2 cycles; cell 3 (row0,col3) valid, owner 0; drop_row=0; turn=1.
- Next, lrp_self put (ignored, not its turn); lrp_opponent put -> cell 10 (row1,col3) owner 1; drop_done at t+3; turn=0.
- Fill column 3 to 6 pieces, then put -> col_full_err pulse after 6 SEARCH cycles; no cell change; turn unchanged.
- 4 left pulses from cursor 3 -> cursor_col 0 (saturate). With CURSOR_WRAP_EN, the 4th pulse -> 6.
- lrp=3'b111 in IDLE -> drop at the current column, cursor unchanged; lrp=3'b110 -> no change. Put during busy -> ignored.
- Fill all 42 cells -> board_full=1 and further puts ignored. rst asserted during SEARCH -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/connect4_pkg.sv
// Shared definitions for the connect-four board controller: default board size,
// command-vector bit positions, FSM state encoding and the flat cell index helper.
package connect4_pkg;

    localparam int DEF_ROWS = 6;
    localparam int DEF_COLS = 7;

    localparam int LRP_LEFT  = 2;
    localparam int LRP_RIGHT = 1;
    localparam int LRP_PUT   = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        WRITE  = 2'd2
    } state_t;

    // Flat board index; row 0 is the bottom row.
    function automatic int cell_idx(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/cursor_ctrl.sv
// Column cursor register with left/right decode and a freeze input.
// Edge behaviour saturates by default; define CURSOR_WRAP_EN to wrap around instead.
module cursor_ctrl #(
    parameter int COLS = 7,
    parameter int CW   = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          left_i,
    input  logic          right_i,
    input  logic          freeze_i,
    output logic [CW-1:0] cursor_o
);

    logic [CW-1:0] cursor_q;
    logic [CW-1:0] cursor_d;

    // Left and right together cancel out.
    always_comb begin
        cursor_d = cursor_q;
        if (!freeze_i) begin
            if (left_i && !right_i) begin
                if (cursor_q != '0) begin
                    cursor_d = cursor_q - CW'(1);
                end
`ifdef CURSOR_WRAP_EN
                else begin
                    cursor_d = CW'(COLS - 1);
                end
`endif
            end else if (right_i && !left_i) begin
                if (cursor_q != CW'(COLS - 1)) begin
                    cursor_d = cursor_q + CW'(1);
                end
`ifdef CURSOR_WRAP_EN
                else begin
                    cursor_d = '0;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cursor_q <= CW'(COLS / 2);
        end else begin
            cursor_q <= cursor_d;
        end
    end

    assign cursor_o = cursor_q;

endmodule

// File: rtl/board_controller.sv
// Connect-four board controller: turn arbitration, cursor, and a row-scan drop FSM.
// Optional build macro CURSOR_WRAP_EN (see cursor_ctrl) makes the cursor wrap at the edges.
module board_controller
    import connect4_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int CW   = 3,
    parameter int RW   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           lrp_self,
    input  logic [2:0]           lrp_opponent,
    input  logic                 player_id,
    output logic [CW-1:0]        cursor_col,
    output logic [ROWS*COLS-1:0] cell_valid,
    output logic [ROWS*COLS-1:0] cell_owner,
    output logic                 turn,
    output logic                 busy,
    output logic                 drop_done,
    output logic [RW-1:0]        drop_row,
    output logic                 col_full_err,
    output logic                 board_full,
    output logic [1:0]           dbg_state
);

    localparam int NCELLS = ROWS * COLS;
    localparam int IW     = $clog2(NCELLS);
    localparam int MW     = $clog2(NCELLS + 1);

    state_t              state_q, state_d;
    logic [RW-1:0]       row_q, row_d;
    logic                turn_q, turn_d;
    logic [NCELLS-1:0]   valid_q, valid_d;
    logic [NCELLS-1:0]   owner_q, owner_d;
    logic                drop_done_q, drop_done_d;
    logic [RW-1:0]       drop_row_q, drop_row_d;
    logic                col_full_err_q, col_full_err_d;
    logic [MW-1:0]       move_cnt_q, move_cnt_d;

    logic [2:0]          active;
    logic                full;
    logic                put_go;
    logic [IW-1:0]       cur_idx;

    assign active  = (turn_q == player_id) ? lrp_self : lrp_opponent;
    assign full    = (move_cnt_q == MW'(NCELLS));
    assign put_go  = (state_q == IDLE) && active[LRP_PUT] && !full;
    assign cur_idx = IW'(cell_idx(int'(row_q), int'(cursor_col), COLS));

    // A put, even one ignored on a full board, takes priority over left/right.
    cursor_ctrl #(
        .COLS(COLS),
        .CW  (CW)
    ) u_cursor (
        .clk_i   (clk),
        .rst_i   (rst),
        .left_i  (active[LRP_LEFT]),
        .right_i (active[LRP_RIGHT]),
        .freeze_i((state_q != IDLE) || active[LRP_PUT]),
        .cursor_o(cursor_col)
    );

    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        turn_d         = turn_q;
        valid_d        = valid_q;
        owner_d        = owner_q;
        drop_done_d    = 1'b0;
        drop_row_d     = drop_row_q;
        col_full_err_d = 1'b0;
        move_cnt_d     = move_cnt_q;
        case (state_q)
            IDLE: begin
                if (put_go) begin
                    state_d = SEARCH;
                    row_d   = '0;
                end
            end
            SEARCH: begin
                if (!valid_q[cur_idx]) begin
                    state_d = WRITE;
                end else if (row_q == RW'(ROWS - 1)) begin
                    col_full_err_d = 1'b1;
                    state_d        = IDLE;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            WRITE: begin
                valid_d[cur_idx] = 1'b1;
                owner_d[cur_idx] = turn_q;
                drop_row_d       = row_q;
                drop_done_d      = 1'b1;
                turn_d           = ~turn_q;
                move_cnt_d       = move_cnt_q + MW'(1);
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            row_q          <= '0;
            turn_q         <= 1'b0;
            valid_q        <= '0;
            owner_q        <= '0;
            drop_done_q    <= 1'b0;
            drop_row_q     <= '0;
            col_full_err_q <= 1'b0;
            move_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            turn_q         <= turn_d;
            valid_q        <= valid_d;
            owner_q        <= owner_d;
            drop_done_q    <= drop_done_d;
            drop_row_q     <= drop_row_d;
            col_full_err_q <= col_full_err_d;
            move_cnt_q     <= move_cnt_d;
        end
    end

    assign cell_valid   = valid_q;
    assign cell_owner   = owner_q;
    assign turn         = turn_q;
    assign busy         = (state_q != IDLE);
    assign drop_done    = drop_done_q;
    assign drop_row     = drop_row_q;
    assign col_full_err = col_full_err_q;
    assign board_full   = full;
    assign dbg_state    = state_q;

endmodule
